// File: rtl/hex_word_uart_tx.sv
// Serialises a 32-bit word as 8 uppercase ASCII hex characters (MSB nibble first)
// on an 8N1 UART line, optionally followed by CR LF.
module hex_word_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          APPEND_CRLF  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int unsigned BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_IDX = APPEND_CRLF ? 4'd9 : 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [3:0]        r_idx;
  logic [31:0]       r_shift;
  logic [7:0]        r_char;
  logic              w_wrap;

  // Character index 8/9 are the line terminator; the nibble is ignored there.
  function automatic logic [7:0] f_char(input logic [3:0] idx, input logic [3:0] nib);
    if (APPEND_CRLF && idx == 4'd8)      f_char = 8'h0D;
    else if (APPEND_CRLF && idx == 4'd9) f_char = 8'h0A;
    else if (nib < 4'd10)                f_char = 8'h30 + {4'h0, nib};
    else                                 f_char = 8'h37 + {4'h0, nib};
  endfunction

  assign w_wrap = (r_baud == BAUD_LAST);

  // NOTE: sequential state uses non-blocking assignments only, and the async reset
  // forces tx high the instant rst rises, aborting any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_char     <= '0;
      tx         <= 1'b1;
      word_ready <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (r_state)
        IDLE: begin
          tx         <= 1'b1;
          word_ready <= 1'b1;
          if (word_ready && word_valid) begin
            word_ready <= 1'b0;
            busy       <= 1'b1;
            tx         <= 1'b0;
            r_state    <= START;
            r_baud     <= '0;
            r_idx      <= '0;
            r_char     <= f_char(4'd0, word_in[31:28]);
            r_shift    <= {word_in[27:0], 4'h0};
          end
        end
        START: begin
          if (w_wrap) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            tx      <= r_char[0];
            r_char  <= {1'b0, r_char[7:1]};
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_wrap) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
              tx      <= 1'b1;
            end else begin
              r_bit  <= r_bit + 1'b1;
              tx     <= r_char[0];
              r_char <= {1'b0, r_char[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_wrap) begin
            r_baud <= '0;
            if (r_idx == LAST_IDX) begin
              r_state    <= IDLE;
              busy       <= 1'b0;
              word_done  <= 1'b1;
              word_ready <= 1'b1;
            end else begin
              // Next character starts with no idle gap after this stop bit.
              r_idx   <= r_idx + 1'b1;
              r_state <= START;
              tx      <= 1'b0;
              r_char  <= f_char(r_idx + 4'd1, r_shift[31:28]);
              r_shift <= {r_shift[27:0], 4'h0};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_word_uart_tx.sv
// Directed bench: decodes the serial line of three instances (fast no-CRLF, fast CRLF,
// full-rate CRLF loopback) and compares against hand-computed ASCII bytes and timings.
module tb_hex_word_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          sel   = 0;

  logic [31:0] a_word, b_word, c_word;
  logic        a_valid, b_valid, c_valid;
  logic        a_ready, b_ready, c_ready;
  logic        a_tx, b_tx, c_tx;
  logic        a_busy, b_busy, c_busy;
  logic        a_done, b_done, c_done;
  logic        s_tx, s_busy, s_ready, s_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hex_word_uart_tx #(.CLKS_PER_BIT(4), .APPEND_CRLF(1'b0)) dut_a (
    .clk(clk), .rst(rst), .word_in(a_word), .word_valid(a_valid), .word_ready(a_ready),
    .tx(a_tx), .busy(a_busy), .word_done(a_done));

  hex_word_uart_tx #(.CLKS_PER_BIT(4), .APPEND_CRLF(1'b1)) dut_b (
    .clk(clk), .rst(rst), .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready),
    .tx(b_tx), .busy(b_busy), .word_done(b_done));

  hex_word_uart_tx #(.CLKS_PER_BIT(434), .APPEND_CRLF(1'b1)) dut_c (
    .clk(clk), .rst(rst), .word_in(c_word), .word_valid(c_valid), .word_ready(c_ready),
    .tx(c_tx), .busy(c_busy), .word_done(c_done));

  always_comb begin
    s_tx = a_tx; s_busy = a_busy; s_ready = a_ready; s_done = a_done;
    case (sel)
      1: begin s_tx = b_tx; s_busy = b_busy; s_ready = b_ready; s_done = b_done; end
      2: begin s_tx = c_tx; s_busy = c_busy; s_ready = c_ready; s_done = c_done; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loader model: ASCII hex digit back to its nibble value.
  function automatic logic [3:0] hex_val(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39)      hex_val = 4'(ch - 8'h30);
    else if (ch >= 8'h41 && ch <= 8'h46) hex_val = 4'(ch - 8'h37);
    else                                 hex_val = 4'h0;
  endfunction

  // Entered on a falling edge; returns on the falling edge of the last stop-bit cycle.
  task automatic rx_byte(input int c, output logic [7:0] b, output int st_lo, output int sp_hi,
                         output int busy_lo, output int ready_hi, output bit tmo);
    int t = 0;
    b = '0; st_lo = 0; sp_hi = 0; busy_lo = 0; ready_hi = 0; tmo = 1'b0;
    while (s_tx !== 1'b0 && t < 30 * c) begin
      @(negedge clk);
      t++;
    end
    if (s_tx !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    for (int i = 0; i < c; i++) begin
      if (s_tx === 1'b0) st_lo++;
      if (s_busy !== 1'b1) busy_lo++;
      if (s_ready !== 1'b0) ready_hi++;
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < c; i++) begin
        if (i == c / 2) b[k] = s_tx;
        if (s_busy !== 1'b1) busy_lo++;
        if (s_ready !== 1'b0) ready_hi++;
        @(negedge clk);
      end
    end
    for (int i = 0; i < c; i++) begin
      if (s_tx === 1'b1) sp_hi++;
      if (s_busy !== 1'b1) busy_lo++;
      if (s_ready !== 1'b0) ready_hi++;
      if (i != c - 1) @(negedge clk);
    end
  endtask

  task automatic rx_word(input int c, input int n, input logic [79:0] exp, input int poke,
                         input string tag, output logic [31:0] word);
    logic [7:0] b;
    logic [7:0] e;
    int st_lo, sp_hi, busy_lo, ready_hi, busy_sum, ready_sum;
    bit tmo;
    busy_sum = 0; ready_sum = 0; word = '0;
    for (int k = 0; k < n; k++) begin
      if (k == poke) begin
        a_word  = 32'hDEADBEEF;
        a_valid = 1'b1;
        @(negedge clk);
        check({tag, "_ready_during_poke"}, 32'(s_ready), 32'd0);
        a_valid = 1'b0;
      end
      rx_byte(c, b, st_lo, sp_hi, busy_lo, ready_hi, tmo);
      check($sformatf("%s_timeout%0d", tag, k), 32'(tmo), 32'd0);
      if (tmo) return;
      e = exp[79 - 8 * k -: 8];
      check($sformatf("%s_byte%0d", tag, k), 32'(b), 32'(e));
      check($sformatf("%s_start_len%0d", tag, k), 32'(st_lo), 32'(c));
      check($sformatf("%s_stop_len%0d", tag, k), 32'(sp_hi), 32'(c));
      busy_sum += busy_lo;
      ready_sum += ready_hi;
      if (k < 8) word = {word[27:0], hex_val(b)};
    end
    check({tag, "_busy_held"}, 32'(busy_sum), 32'd0);
    check({tag, "_ready_low"}, 32'(ready_sum), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int t0;
    int idle_bad;

    rst = 1'b1;
    a_word = '0; b_word = '0; c_word = '0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(a_tx), 32'd1);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(a_ready), 32'd1);

    // 0x1234ABCD, no CRLF: 320 bit-cycles, word_done in cycle 321.
    sel = 0;
    a_word = 32'h1234ABCD; a_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    a_valid = 1'b0; a_word = 32'h0;
    check("t1_start_latency", 32'(a_tx), 32'd0);
    check("t1_busy", 32'(a_busy), 32'd1);
    check("t1_ready", 32'(a_ready), 32'd0);
    rx_word(4, 8, {64'h31323334_41424344, 16'h0}, -1, "t1", w);
    check("t1_done_early", 32'(a_done), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(a_done), 32'd1);
    check("t1_done_cycles", 32'(cyc - t0), 32'd320);
    check("t1_busy_end", 32'(a_busy), 32'd0);
    check("t1_ready_end", 32'(a_ready), 32'd1);
    check("t1_tx_idle", 32'(a_tx), 32'd1);
    @(negedge clk);
    check("t1_done_pulse", 32'(a_done), 32'd0);

    // 0x00000000 with CRLF: 400 bit-cycles.
    sel = 1;
    b_word = 32'h0; b_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    b_valid = 1'b0;
    rx_word(4, 10, 80'h30303030_30303030_0D0A, -1, "t2", w);
    @(negedge clk);
    check("t2_done", 32'(b_done), 32'd1);
    check("t2_done_cycles", 32'(cyc - t0), 32'd400);

    // 0xFFFFFFFF with an ignored 0xDEADBEEF offer before the 4th character.
    sel = 0;
    a_word = 32'hFFFFFFFF; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    rx_word(4, 8, {64'h46464646_46464646, 16'h0}, 3, "t3", w);
    @(negedge clk);
    check("t3_done", 32'(a_done), 32'd1);
    check("t3_ready_end", 32'(a_ready), 32'd1);
    idle_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0) idle_bad++;
    end
    check("t3_no_queued_word", 32'(idle_bad), 32'd0);

    // Reset during bit 1 of the 3rd character ('5' = 0x35, bit1 = 0).
    a_word = 32'h13579BDF; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    rx_word(4, 2, {16'h3133, 64'h0}, -1, "t4", w);
    @(negedge clk);
    repeat (9) @(negedge clk);
    check("t4_tx_before_rst", 32'(a_tx), 32'd0);
    check("t4_busy_before_rst", 32'(a_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t4_tx_on_rst", 32'(a_tx), 32'd1);
    check("t4_busy_on_rst", 32'(a_busy), 32'd0);
    check("t4_ready_on_rst", 32'(a_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t4_ready_held", 32'(a_ready), 32'd0);
    @(negedge clk);
    check("t4_ready_first_edge", 32'(a_ready), 32'd1);
    check("t4_tx_idle", 32'(a_tx), 32'd1);
    check("t4_no_done", 32'(a_done), 32'd0);
    a_word = 32'h89ABCDEF; a_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    a_valid = 1'b0;
    rx_word(4, 8, {64'h38394142_43444546, 16'h0}, -1, "t4b", w);
    @(negedge clk);
    check("t4b_done", 32'(a_done), 32'd1);
    check("t4b_done_cycles", 32'(cyc - t0), 32'd320);

    // Back-to-back with word_valid held high; word_in changes after acceptance.
    a_word = 32'h0F0F0F0F; a_valid = 1'b1;
    @(negedge clk);
    a_word = 32'h76543210;
    check("t5_start", 32'(a_tx), 32'd0);
    rx_word(4, 8, {64'h30463046_30463046, 16'h0}, -1, "t5a", w);
    @(negedge clk);
    check("t5_gap_tx", 32'(a_tx), 32'd1);
    check("t5_gap_done", 32'(a_done), 32'd1);
    check("t5_gap_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    check("t5_second_start", 32'(a_tx), 32'd0);
    check("t5_second_busy", 32'(a_busy), 32'd1);
    check("t5_second_done", 32'(a_done), 32'd0);
    a_valid = 1'b0;
    rx_word(4, 8, {64'h37363534_33323130, 16'h0}, -1, "t5b", w);
    @(negedge clk);
    check("t5b_done", 32'(a_done), 32'd1);

    // Full-rate loopback through the hex loader model.
    sel = 2;
    c_word = 32'hCAFE1234; c_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    c_valid = 1'b0;
    rx_word(434, 10, 80'h43414645_31323334_0D0A, -1, "t6", w);
    check("t6_loader_word", w, 32'hCAFE1234);
    @(negedge clk);
    check("t6_done", 32'(c_done), 32'd1);
    check("t6_done_cycles", 32'(cyc - t0), 32'd43400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
